change_dispenser: RTL and testbench

Downstream stage of the drink-seller controller. Takes the change amount the seller produces after a drink is vended and pays it out as a sequence of physical coins, one hopper handshake per coin. Uses a greedy largest-denomination-first policy and skips empty coin tubes. If the amount cannot be paid from the remaining tubes, it reports a fault along with the unpaid balance.

---
 rtl/change_dispenser.sv | 138 +++++++++++++
 tb/tb_change_dispenser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin payout stage: pays a change amount as HI/MID/LO coins, one hopper handshake per coin.
// Optional ack-wait timeout enabled by defining CHANGE_ACK_TIMEOUT_EN.
module change_dispenser #(
    parameter int WIDTH       = 8,
    parameter int DENOM_HI    = 10,
    parameter int DENOM_MID   = 5,
    parameter int DENOM_LO    = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] amount,
    input  logic [2:0]       tube_empty,
    input  logic             coin_ack,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [WIDTH-1:0] HI_VAL  = WIDTH'(DENOM_HI);
    localparam logic [WIDTH-1:0] MID_VAL = WIDTH'(DENOM_MID);
    localparam logic [WIDTH-1:0] LO_VAL  = WIDTH'(DENOM_LO);

    localparam logic [1:0] COIN_HI  = 2'b11;
    localparam logic [1:0] COIN_MID = 2'b10;
    localparam logic [1:0] COIN_LO  = 2'b01;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] remaining_reg, remaining_next;
    logic [1:0]       type_reg, type_next;
    logic [WIDTH-1:0] issue_value;
    logic             timeout_hit;

`ifdef CHANGE_ACK_TIMEOUT_EN
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    // Counter sits at zero outside ISSUE, so it is cleared on every entry to ISSUE.
    logic [CNT_W-1:0] wait_cnt_reg;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wait_cnt_reg <= '0;
        end else if (state_reg != S_ISSUE || coin_ack) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
        end
    end

    assign timeout_hit = (state_reg == S_ISSUE) && !coin_ack &&
                         (wait_cnt_reg == CNT_W'(ACK_TIMEOUT - 1));
`else
    // Without the timeout the parameter only documents the interface; this is never true.
    assign timeout_hit = (ACK_TIMEOUT < 0);
`endif

    always_comb begin
        case (type_reg)
            COIN_HI:  issue_value = HI_VAL;
            COIN_MID: issue_value = MID_VAL;
            default:  issue_value = LO_VAL;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        type_next      = type_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    remaining_next = amount;
                    state_next     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_reg == '0) begin
                    state_next = S_DONE;
                end else if (!tube_empty[2] && remaining_reg >= HI_VAL) begin
                    type_next  = COIN_HI;
                    state_next = S_ISSUE;
                end else if (!tube_empty[1] && remaining_reg >= MID_VAL) begin
                    type_next  = COIN_MID;
                    state_next = S_ISSUE;
                end else if (!tube_empty[0] && remaining_reg >= LO_VAL) begin
                    type_next  = COIN_LO;
                    state_next = S_ISSUE;
                end else begin
                    state_next = S_FAULT;
                end
            end
            S_ISSUE: begin
                // An ack on the final wait cycle still wins over the timeout.
                if (coin_ack) begin
                    remaining_next = remaining_reg - issue_value;
                    state_next     = S_SELECT;
                end else if (timeout_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_FAULT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            type_reg      <= 2'b00;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            type_reg      <= type_next;
        end
    end

    assign coin_valid = (state_reg == S_ISSUE);
    assign coin_type  = coin_valid ? type_reg : 2'b00;
    assign busy       = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);
    assign fault      = (state_reg == S_FAULT);
    assign remaining  = remaining_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy-payout reference model.
module tb_change_dispenser;

    localparam int W  = 8;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         clear_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] amount = '0;
    logic [2:0]   tube_empty = 3'b000;
    logic         coin_ack = 1'b0;
    logic         coin_valid;
    logic [1:0]   coin_type;
    logic         busy;
    logic         done;
    logic         fault;
    logic [W-1:0] remaining;

    int total = 0;
    int bad   = 0;

    change_dispenser #(
        .WIDTH(W), .DENOM_HI(10), .DENOM_MID(5), .DENOM_LO(1), .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .amount(amount),
        .tube_empty(tube_empty), .coin_ack(coin_ack), .coin_valid(coin_valid),
        .coin_type(coin_type), .busy(busy), .done(done), .fault(fault),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_value(input int code);
        return (code == 3) ? 10 : (code == 2) ? 5 : 1;
    endfunction

    // Greedy payout: largest available coin not exceeding the balance, until zero or stuck.
    task automatic model(input int amt, input logic [2:0] te, output int coins[$],
                         output int rem, output bit flt);
        int vals[3] = '{10, 5, 1};
        coins = {};
        rem   = amt;
        flt   = 1'b0;
        while (rem != 0) begin
            int pick;
            pick = -1;
            for (int i = 0; i < 3; i++)
                if (pick < 0 && !te[2-i] && vals[i] <= rem) pick = i;
            if (pick < 0) begin
                flt = 1'b1;
                break;
            end
            coins.push_back(3 - pick);
            rem -= vals[pick];
        end
    endtask

    task automatic run_txn(input int amt, input logic [2:0] te, input int maxw,
                           input bit fixed_wait, input bit noise);
        int coins[$];
        int rem_exp;
        bit flt;
        int run_rem;
        int w;
        model(amt, te, coins, rem_exp, flt);
        check_val("idle_busy", busy, 0);
        start = 1'b1; amount = W'(amt); tube_empty = te;
        tick();
        start = 1'b0; amount = W'($urandom);
        check_val("sel0_busy", busy, 1);
        check_val("sel0_valid", coin_valid, 0);
        check_val("sel0_rem", remaining, amt);
        run_rem = amt;
        foreach (coins[i]) begin
            coin_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            coin_ack = 1'b0;
            check_val("issue_valid", coin_valid, 1);
            check_val("issue_type", coin_type, coins[i]);
            w = fixed_wait ? maxw : $urandom_range(0, maxw);
            for (int j = 0; j < w; j++) begin
                if (noise) begin
                    tube_empty = 3'($urandom);
                    start = 1'($urandom_range(0, 1));
                    amount = W'($urandom);
                end
                tick();
                start = 1'b0;
                check_val("wait_valid", coin_valid, 1);
                check_val("wait_type", coin_type, coins[i]);
                check_val("wait_rem", remaining, run_rem);
            end
            tube_empty = te;
            coin_ack = 1'b1;
            tick();
            coin_ack = 1'b0;
            run_rem -= coin_value(coins[i]);
            check_val("sel_valid", coin_valid, 0);
            check_val("sel_type", coin_type, 0);
            check_val("sel_rem", remaining, run_rem);
        end
        tick();
        check_val("end_done", done, !flt);
        check_val("end_fault", fault, flt);
        check_val("end_rem", remaining, rem_exp);
        check_val("end_busy", busy, 1);
        if (noise) begin
            start = 1'b1;
            amount = W'($urandom);
        end
        tick();
        start = 1'b0;
        check_val("post_busy", busy, 0);
        check_val("post_pulse", {done, fault}, 0);
        check_val("post_rem", remaining, rem_exp);
        $display("txn amount=%0d tubes=%b coins=%0d result=%s rem=%0d",
                 amt, te, coins.size(), flt ? "fault" : "done", rem_exp);
    endtask

    initial begin
        repeat (3) tick();
        check_val("rst_outputs", {coin_valid, coin_type, busy, done, fault, remaining}, 0);
        @(negedge clk) clear_n = 1'b1;
        tick();

        run_txn(25, 3'b000, 0, 1'b1, 1'b0);
        run_txn(17, 3'b100, 0, 1'b1, 1'b0);
        run_txn(7,  3'b011, 0, 1'b1, 1'b0);
        run_txn(12, 3'b000, 3, 1'b1, 1'b1);
        run_txn(0,  3'b000, 0, 1'b1, 1'b1);

        // Reset in the middle of the second coin handshake.
        start = 1'b1; amount = 30; tube_empty = 3'b000;
        tick();
        start = 1'b0;
        tick();
        check_val("rst_issue1_type", coin_type, 3);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        tick();
        check_val("rst_issue2_valid", coin_valid, 1);
        #2 clear_n = 1'b0;
        #1;
        check_val("rst_mid_outputs", {coin_valid, coin_type, busy, done, fault, remaining}, 0);
        @(negedge clk) clear_n = 1'b1;
        tick();
        $display("txn amount=30 tubes=000 result=reset");
        run_txn(5, 3'b000, 0, 1'b1, 1'b0);

`ifdef CHANGE_ACK_TIMEOUT_EN
        start = 1'b1; amount = 10; tube_empty = 3'b000;
        tick();
        start = 1'b0;
        for (int i = 0; i < TO; i++) begin
            tick();
            check_val("to_valid", coin_valid, 1);
            check_val("to_type", coin_type, 3);
        end
        tick();
        check_val("to_fault", fault, 1);
        check_val("to_valid_drop", coin_valid, 0);
        check_val("to_rem", remaining, 10);
        tick();
        check_val("to_idle", busy, 0);
        $display("txn amount=10 tubes=000 result=timeout rem=10");
`endif

        for (int n = 0; n < 40; n++)
            run_txn($urandom_range(0, 100), 3'($urandom), TO - 1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
